// File: rtl/data_mem_responder_if.sv
// Load/store port bundle between the core (master) and the wait-state data memory (slave).
interface data_mem_responder_if #(
  parameter int ADDR_W = 7
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic              mem_err;
  logic              busy;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata, mem_err, busy
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata, mem_err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Wait-state word memory: accepts one request, waits WAIT_CYCLES, then answers with a
// one-cycle ready pulse carrying read data or an error for misaligned/out-of-range addresses.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 32,
  parameter int ADDR_W      = 7,
  parameter int WAIT_CYCLES = 2
) (
  input logic               clk,
  input logic               reset,
  data_mem_responder_if.slave bus
);

  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  logic [3:0]        cnt;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              fire;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic              acc_err;
  logic              wr_en;
  logic [IDX_W-1:0]  widx;
  logic [31:0]       rd_word;

  logic              ready_r;
  logic              err_r;
  logic              busy_r;
  logic [31:0]       rdata_r;

  function automatic logic access_err(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-3:0] idx;
    idx = a[ADDR_W-1:2];
    return (a[1:0] != 2'b00) || (int'(idx) >= DEPTH_WORDS);
  endfunction

  // With zero wait cycles the access happens on the accepting edge, so the live
  // request fields are used instead of the not-yet-written latched copies.
  always_comb begin
    fire      = 1'b0;
    acc_we    = lat_we;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    case (state)
      S_IDLE: begin
        fire      = bus.mem_req && (WAIT_CYCLES == 0);
        acc_we    = bus.mem_we;
        acc_addr  = bus.mem_addr;
        acc_wdata = bus.mem_wdata;
      end
      S_WAIT:  fire = (cnt == 4'd0);
      default: fire = 1'b0;
    endcase
    acc_err = access_err(acc_addr);
    widx    = acc_addr[IDX_W+1:2];
    wr_en   = fire && acc_we && !acc_err;
    rd_word = mem[widx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[widx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.mem_req) begin
      lat_we    <= bus.mem_we;
      lat_addr  <= bus.mem_addr;
      lat_wdata <= bus.mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      rdata_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ready_r <= 1'b0;
          err_r   <= 1'b0;
          if (bus.mem_req) begin
            busy_r <= 1'b1;
            state  <= S_WAIT;
            cnt    <= WAIT_INIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        S_RESP: begin
          state   <= S_IDLE;
          ready_r <= 1'b0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
      if (fire) begin
        state   <= S_RESP;
        ready_r <= 1'b1;
        err_r   <= acc_err;
        if (acc_err)     rdata_r <= '0;
        else if (acc_we) rdata_r <= acc_wdata;
        else             rdata_r <= rd_word;
      end
    end
  end

  assign bus.mem_ready = ready_r;
  assign bus.mem_err   = err_r;
  assign bus.busy      = busy_r;
  assign bus.mem_rdata = rdata_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three builds (default, 16-word, zero-wait) checked against a word-array model.
module tb_data_mem_responder;

  typedef struct packed {
    logic        ready;
    logic        err;
    logic        busy;
    logic [31:0] rdata;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nchk = 0;
  int   nfail = 0;

  logic [31:0] mdl [3][32];

  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_W(7)) ifm ();
  data_mem_responder_if #(.ADDR_W(7)) if16 ();
  data_mem_responder_if #(.ADDR_W(7)) if0 ();

  data_mem_responder #(.DEPTH_WORDS(32), .ADDR_W(7), .WAIT_CYCLES(2))
    u_main (.clk(clk), .reset(reset), .bus(ifm));
  data_mem_responder #(.DEPTH_WORDS(16), .ADDR_W(7), .WAIT_CYCLES(2))
    u_d16 (.clk(clk), .reset(reset), .bus(if16));
  data_mem_responder #(.DEPTH_WORDS(32), .ADDR_W(7), .WAIT_CYCLES(0))
    u_w0 (.clk(clk), .reset(reset), .bus(if0));

  function automatic obs_t obs(input int sel);
    obs_t o;
    case (sel)
      0:       o = {ifm.mem_ready, ifm.mem_err, ifm.busy, ifm.mem_rdata};
      1:       o = {if16.mem_ready, if16.mem_err, if16.busy, if16.mem_rdata};
      default: o = {if0.mem_ready, if0.mem_err, if0.busy, if0.mem_rdata};
    endcase
    return o;
  endfunction

  task automatic drive(input int sel, input logic req, input logic we,
                       input logic [6:0] a, input logic [31:0] wd);
    case (sel)
      0: begin ifm.mem_req = req; ifm.mem_we = we; ifm.mem_addr = a; ifm.mem_wdata = wd; end
      1: begin if16.mem_req = req; if16.mem_we = we; if16.mem_addr = a; if16.mem_wdata = wd; end
      default: begin if0.mem_req = req; if0.mem_we = we; if0.mem_addr = a; if0.mem_wdata = wd; end
    endcase
  endtask

  // Reference: word index is addr/4; misaligned or beyond the build's depth is an error.
  task automatic model(input int sel, input logic we, input logic [6:0] a,
                       input logic [31:0] wd, output logic e, output logic [31:0] rd);
    int ai    = int'(a);
    int depth = (sel == 1) ? 16 : 32;
    int idx   = ai / 4;
    e  = (ai % 4 != 0) || (idx >= depth);
    rd = 32'h0;
    if (!e) begin
      if (we) begin
        mdl[sel][idx] = wd;
        rd = wd;
      end else begin
        rd = mdl[sel][idx];
      end
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 32; i++) mdl[s][i] = 32'h0;
  endtask

  // One request; lat = edges after acceptance until ready is seen (-1 if never).
  task automatic txn(input int sel, input logic we, input logic [6:0] a, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd, output logic er,
                     output logic bsy, output logic [1:0] aft);
    obs_t o;
    lat = -1; rd = 32'h0; er = 1'b0; aft = 2'b11;
    @(negedge clk);
    drive(sel, 1'b1, we, a, wd);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'($urandom), 7'($urandom), $urandom);
    o   = obs(sel);
    bsy = o.busy;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      o = obs(sel);
      if (o.ready) begin
        lat = k; rd = o.rdata; er = o.err;
        break;
      end
    end
    if (lat >= 0) begin
      @(posedge clk);
      #1;
      o   = obs(sel);
      aft = {o.ready, o.busy};
    end
  endtask

  task automatic test_reset();
    obs_t o;
    int lat; logic [31:0] rd; logic er, bsy; logic [1:0] aft;
    logic [6:0] a;
    reset = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, 7'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      o = obs(s);
      nchk++;
      if (o !== obs_t'(0))
        begin nfail++; $display("FAIL reset_outputs dut%0d: got %h, expected 0", s, o); end
    end
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    a = 7'($urandom_range(0, 31) * 4);
    txn(0, 1'b0, a, 32'h0, lat, rd, er, bsy, aft);
    nchk++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0)
      begin nfail++; $display("FAIL reset_cleared_word @%h: lat=%0d err=%b rdata=%h, expected lat=2 err=0 rdata=0", a, lat, er, rd); end
  endtask

  task automatic test_reset_mid_wait();
    obs_t o;
    logic seen;
    int lat; logic [31:0] rd; logic er, bsy; logic [1:0] aft;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 7'h10, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 7'h0, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    o = obs(0);
    nchk++;
    if ({o.ready, o.busy} !== 2'b00)
      begin nfail++; $display("FAIL reset_abort_immediate: ready=%b busy=%b, expected 0 0", o.ready, o.busy); end
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; o = obs(0); if (o.ready) seen = 1'b1; end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin @(posedge clk); #1; o = obs(0); if (o.ready) seen = 1'b1; end
    nchk++;
    if (seen !== 1'b0)
      begin nfail++; $display("FAIL reset_abort_no_ready: ready seen=%b, expected 0", seen); end
    clear_model();
    txn(0, 1'b0, 7'h10, 32'h0, lat, rd, er, bsy, aft);
    nchk++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0)
      begin nfail++; $display("FAIL reset_abort_load: lat=%0d err=%b rdata=%h, expected lat=2 err=0 rdata=0", lat, er, rd); end
  endtask

  task automatic test_store_load_latency();
    int lat; logic [31:0] rd, me; logic er, bsy, ee; logic [1:0] aft;
    model(0, 1'b1, 7'h08, 32'h12345678, ee, me);
    txn(0, 1'b1, 7'h08, 32'h12345678, lat, rd, er, bsy, aft);
    nchk++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h12345678)
      begin nfail++; $display("FAIL store_latency: lat=%0d err=%b rdata=%h, expected lat=2 err=0 rdata=12345678", lat, er, rd); end
    nchk++;
    if (bsy !== 1'b1 || aft !== 2'b00)
      begin nfail++; $display("FAIL store_busy_pulse: busy_at_accept=%b after={ready,busy}=%b, expected 1 and 00", bsy, aft); end
    model(0, 1'b0, 7'h08, 32'h0, ee, me);
    txn(0, 1'b0, 7'h08, 32'h0, lat, rd, er, bsy, aft);
    nchk++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h12345678)
      begin nfail++; $display("FAIL load_latency: lat=%0d err=%b rdata=%h, expected lat=2 err=0 rdata=12345678", lat, er, rd); end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd, me; logic er, bsy, ee; logic [1:0] aft;
    model(0, 1'b1, 7'h09, 32'hFFFFFFFF, ee, me);
    txn(0, 1'b1, 7'h09, 32'hFFFFFFFF, lat, rd, er, bsy, aft);
    nchk++;
    if (lat !== 2 || er !== 1'b1 || rd !== 32'h0)
      begin nfail++; $display("FAIL misaligned_store: lat=%0d err=%b rdata=%h, expected lat=2 err=1 rdata=0", lat, er, rd); end
    txn(0, 1'b0, 7'h08, 32'h0, lat, rd, er, bsy, aft);
    nchk++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h12345678)
      begin nfail++; $display("FAIL misaligned_no_write: lat=%0d err=%b rdata=%h, expected lat=2 err=0 rdata=12345678", lat, er, rd); end
  endtask

  task automatic test_boundary();
    int lat; logic [31:0] rd, me; logic er, bsy, ee; logic [1:0] aft;
    logic [6:0]  ba [2] = '{7'h7C, 7'h00};
    logic [31:0] bv [2] = '{32'hA5A5A5A5, 32'h5A5A5A5A};
    for (int i = 0; i < 2; i++) begin
      model(0, 1'b1, ba[i], bv[i], ee, me);
      txn(0, 1'b1, ba[i], bv[i], lat, rd, er, bsy, aft);
    end
    for (int i = 0; i < 2; i++) begin
      txn(0, 1'b0, ba[i], 32'h0, lat, rd, er, bsy, aft);
      nchk++;
      if (lat !== 2 || er !== 1'b0 || rd !== bv[i])
        begin nfail++; $display("FAIL boundary_load @%h: lat=%0d err=%b rdata=%h, expected lat=2 err=0 rdata=%h", ba[i], lat, er, rd, bv[i]); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int lat; logic [31:0] rd, me; logic er, bsy, ee; logic [1:0] aft;
    int pulses[$];
    logic [31:0] got[$];
    logic [31:0] expv [3];
    int expt [3] = '{2, 6, 10};
    for (int i = 0; i < 3; i++) begin
      logic [31:0] v = $urandom;
      model(0, 1'b1, 7'(i * 4), v, ee, me);
      txn(0, 1'b1, 7'(i * 4), v, lat, rd, er, bsy, aft);
      expv[i] = v;
    end
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 7'h00, $urandom);
    @(posedge clk);
    for (int t = 0; t <= 16; t++) begin
      if (t > 0) @(posedge clk);
      #1;
      o = obs(0);
      if (o.ready) begin pulses.push_back(t); got.push_back(o.rdata); end
      if (t == 3)      drive(0, 1'b1, 1'b0, 7'h04, $urandom);
      else if (t == 7) drive(0, 1'b1, 1'b0, 7'h08, $urandom);
      else if (t >= 8) drive(0, 1'b0, 1'b0, 7'h00, 32'h0);
      else             drive(0, 1'b1, 1'($urandom), 7'($urandom), $urandom);
    end
    nchk++;
    if (pulses.size() !== 3)
      begin nfail++; $display("FAIL b2b_pulse_count: got %0d pulses, expected 3", pulses.size()); end
    for (int i = 0; i < 3 && i < pulses.size(); i++) begin
      nchk++;
      if (pulses[i] !== expt[i] || got[i] !== expv[i])
        begin nfail++; $display("FAIL b2b_pulse%0d: cycle=%0d rdata=%h, expected cycle=%0d rdata=%h", i, pulses[i], got[i], expt[i], expv[i]); end
    end
  endtask

  task automatic test_depth16();
    int lat; logic [31:0] rd, me; logic er, bsy, ee; logic [1:0] aft;
    logic [31:0] v = $urandom;
    logic [6:0]  oa [2] = '{7'h40, 7'h7C};
    model(1, 1'b1, 7'h3C, v, ee, me);
    txn(1, 1'b1, 7'h3C, v, lat, rd, er, bsy, aft);
    txn(1, 1'b0, 7'h3C, 32'h0, lat, rd, er, bsy, aft);
    nchk++;
    if (lat !== 2 || er !== 1'b0 || rd !== v)
      begin nfail++; $display("FAIL d16_last_word: lat=%0d err=%b rdata=%h, expected lat=2 err=0 rdata=%h", lat, er, rd, v); end
    for (int i = 0; i < 2; i++) begin
      txn(1, 1'b1, oa[i], $urandom, lat, rd, er, bsy, aft);
      nchk++;
      if (lat !== 2 || er !== 1'b1 || rd !== 32'h0)
        begin nfail++; $display("FAIL d16_out_of_range @%h: lat=%0d err=%b rdata=%h, expected lat=2 err=1 rdata=0", oa[i], lat, er, rd); end
    end
    txn(1, 1'b0, 7'h00, 32'h0, lat, rd, er, bsy, aft);
    nchk++;
    if (lat !== 2 || er !== 1'b0 || rd !== mdl[1][0])
      begin nfail++; $display("FAIL d16_no_alias: rdata=%h err=%b, expected rdata=%h err=0", rd, er, mdl[1][0]); end
  endtask

  task automatic test_wait0();
    obs_t o;
    int lat; logic [31:0] rd, me; logic er, bsy, ee; logic [1:0] aft;
    int pulses[$];
    logic [31:0] got[$];
    logic [31:0] expv [3];
    int expt [3] = '{0, 2, 4};
    for (int i = 0; i < 3; i++) begin
      logic [31:0] v = $urandom;
      model(2, 1'b1, 7'(i * 4), v, ee, me);
      txn(2, 1'b1, 7'(i * 4), v, lat, rd, er, bsy, aft);
      expv[i] = v;
    end
    txn(2, 1'b0, 7'h04, 32'h0, lat, rd, er, bsy, aft);
    nchk++;
    if (lat !== 0 || er !== 1'b0 || rd !== expv[1] || bsy !== 1'b1 || aft !== 2'b00)
      begin nfail++; $display("FAIL w0_load_latency: lat=%0d err=%b rdata=%h busy=%b after=%b, expected lat=0 err=0 rdata=%h busy=1 after=00", lat, er, rd, bsy, aft, expv[1]); end
    @(negedge clk);
    drive(2, 1'b1, 1'b0, 7'h00, $urandom);
    @(posedge clk);
    for (int t = 0; t <= 8; t++) begin
      if (t > 0) @(posedge clk);
      #1;
      o = obs(2);
      if (o.ready) begin pulses.push_back(t); got.push_back(o.rdata); end
      if (t == 1)      drive(2, 1'b1, 1'b0, 7'h04, $urandom);
      else if (t == 3) drive(2, 1'b1, 1'b0, 7'h08, $urandom);
      else if (t >= 4) drive(2, 1'b0, 1'b0, 7'h00, 32'h0);
      else             drive(2, 1'b1, 1'($urandom), 7'($urandom), $urandom);
    end
    nchk++;
    if (pulses.size() !== 3)
      begin nfail++; $display("FAIL w0_pulse_count: got %0d pulses, expected 3", pulses.size()); end
    for (int i = 0; i < 3 && i < pulses.size(); i++) begin
      nchk++;
      if (pulses[i] !== expt[i] || got[i] !== expv[i])
        begin nfail++; $display("FAIL w0_pulse%0d: cycle=%0d rdata=%h, expected cycle=%0d rdata=%h", i, pulses[i], got[i], expt[i], expv[i]); end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd, me, wd; logic er, bsy, ee, we; logic [1:0] aft;
    logic [6:0] a;
    int sel;
    for (int n = 0; n < 60; n++) begin
      sel = (n % 3 == 2) ? 1 : 0;
      we  = 1'($urandom);
      a   = 7'($urandom);
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      wd  = $urandom;
      model(sel, we, a, wd, ee, me);
      txn(sel, we, a, wd, lat, rd, er, bsy, aft);
      nchk++;
      if (lat !== 2 || er !== ee || rd !== me || bsy !== 1'b1 || aft !== 2'b00)
        begin nfail++; $display("FAIL random%0d dut%0d we=%b @%h: lat=%0d err=%b rdata=%h busy=%b after=%b, expected lat=2 err=%b rdata=%h busy=1 after=00", n, sel, we, a, lat, er, rd, bsy, aft, ee, me); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_wait();
    test_store_load_latency();
    test_misaligned();
    test_boundary();
    test_back_to_back();
    test_depth16();
    test_wait0();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
